regbank_dump: RTL
=================

# regbank_dump

Sequential read-out engine for the 32 x 32 register bank. On `start` it walks an address range, drives the bank's combinational read-select port, and captures each word into an output register. Each captured word is streamed out with its address over a valid/ready handshake. It sits beside the register bank and feeds a debug/scan path or a context-save buffer, reading the bank while the write port keeps its normal owner.

## Interface
- `NREG`, default 32: number of registers in the bank; must equal 2**AW.
- `AW`, default 5: register address width.
- `DW`, default 32: data word width.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  request a dump; sampled only in IDLE.
- `first`  in  AW  first register index, latched with `start`.
- `last`  in  AW  last register index, latched with `start`.
- `abort`  in  1  cancel the dump in progress.
- `rdAddr`  out  AW  read select driven to the bank's `sr` port.
- `rdData`  in  DW  combinational read data returned from the bank.
- `outData`  out  DW  captured register word.
- `outAddr`  out  AW  index of `outData`.
- `outValid`  out  1  `outData`/`outAddr` valid.
- `outReady`  in  1  consumer accepts the word this cycle.
- `busy`  out  1  high when state != IDLE.
- `done`  out  1  one-cycle pulse after the final word is accepted.

## Operation
- States are IDLE, FETCH and SEND.
- IDLE:
  - `start`=1 latches `first` into pointer `ptr` and `last` into `endIdx`, then goes to FETCH.
  - `start` is ignored in FETCH and SEND.
- FETCH:
  - `rdAddr`=`ptr`.
  - At the clock edge, `rdData` is captured into `outData` and `ptr` into `outAddr`, and the state goes to SEND.
- SEND:
  - `outValid`=1, and `outData`/`outAddr` are held stable until the handshake.
  - The handshake is `outValid` & `outReady` at a rising edge.
  - If `ptr`==`endIdx`, go to IDLE and pulse `done` in the next cycle.
  - Otherwise `ptr` <= (`ptr`+1) mod NREG and go to FETCH.
- Wrap-around:
  - If `first` > `last`, the range runs `first`..NREG-1, then 0..`last`.
  - If `first` == `last`, exactly one word is sent.
  - The pointer increment is AW-bit and wraps naturally.
- Snapshot semantics: each word reflects the bank contents in its own FETCH cycle. Bank writes after that capture are not reflected in the word.
- `rdAddr` is registered (equal to `ptr`) in all states and does not glitch combinationally.
- Abort:
  - `abort`=1 in FETCH or SEND forces IDLE at the next edge.
  - `outValid` drops and no `done` pulse is produced.
  - This is the only case in which `outValid` falls without a handshake.
  - `abort` takes priority over a same-cycle handshake, so that word counts as not transferred.
  - `abort` in IDLE has no effect.
- A `start` in the same cycle as a `done` pulse (state IDLE) is accepted.
- Reset values:
  - state=IDLE.
  - `ptr`, `endIdx`, `rdAddr`, `outAddr` = 0.
  - `outData` = 0.
  - `outValid`, `busy`, `done` = 0.
- Reset is asynchronous, so assertion mid-dump clears everything immediately, drops `outValid`, and gives no `done`.

## Timing
- Cycle 0: IDLE, `start`=1.
- Cycle 1: FETCH, `rdAddr`=`first`, `busy`=1.
- Cycle 2: SEND, `outValid`=1, `outData`=bank[`first`].
- Throughput is 1 word per 2 cycles with `outReady` tied high. Each stalled cycle (`outReady`=0) adds 1 cycle.
- If the final handshake is in cycle N, then in cycle N+1 `done`=1, `busy`=0 and `outValid`=0.
- A single-word dump with `outReady`=1 pulses `done` in cycle 3.
- A full 0..31 dump with `outReady`=1 has handshakes in cycles 2,4,…,64 and pulses `done` in cycle 65.
- Read latency from `rdAddr` to capture is 0 cycles, which relies on the bank's combinational read.

## Test plan
- Full dump: preload bank[k]=32'hA500_0000+k, first=0, last=31, outReady=1 -> 32 words in order with outAddr=k and outData=A500_0000+k, handshakes on even cycles 2..64, done in cycle 65 only.
- Wrap range: first=30, last=1 -> outAddr sequence 30,31,0,1, then exactly one done pulse.
- Backpressure: first=last=7, outReady held 0 for 5 cycles after outValid rises -> outValid/outData/outAddr stable for all 5 cycles, handshake on the first ready cycle, done next cycle.
- Snapshot: write bank[3]=32'h1111 before FETCH of index 3, then 32'h2222 during its SEND -> outData=32'h1111.
- Abort/ignore: start with first=0, last=31; assert start again in cycle 1 (ignored); assert abort in SEND of the 4th word -> next cycle IDLE, outValid=0, busy=0, no done pulse.
- Reset mid-dump: drive rst=0 asynchronously between edges during SEND -> outValid, busy, done, outData, rdAddr all 0 immediately. After release, a new start dumps correctly from its own first.

Source files
------------

// File: rtl/regbank_dump.sv
// Sequential read-out engine: walks a (possibly wrapping) register index range,
// captures each word from the bank's combinational read port and streams it out.
module regbank_dump #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_first,
  input  logic [AW-1:0] i_last,
  input  logic          i_abort,
  output logic [AW-1:0] o_rd_addr,
  input  logic [DW-1:0] i_rd_data,
  output logic [DW-1:0] o_out_data,
  output logic [AW-1:0] o_out_addr,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  localparam logic [AW-1:0] LP_LAST_IDX = AW'(NREG - 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [AW-1:0] r_end_idx;
  logic [AW-1:0] r_out_addr;
  logic [DW-1:0] r_out_data;
  logic          r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_end_idx  <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ptr     <= i_first;
            r_end_idx <= i_last;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_out_data <= i_rd_data;
            r_out_addr <= r_ptr;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          // abort wins over a same-cycle handshake: that word is dropped
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (i_out_ready) begin
            if (r_ptr == r_end_idx) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_ptr   <= (r_ptr == LP_LAST_IDX) ? '0 : r_ptr + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // the read select is the pointer register itself, so it never glitches
  assign o_rd_addr   = r_ptr;
  assign o_out_data  = r_out_data;
  assign o_out_addr  = r_out_addr;
  assign o_out_valid = (r_state == S_SEND);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule
